sl3p_tx_am_insert_2ln: RTL and testbench
========================================

Name: sl3p_tx_am_insert_2ln

Overview:
TX framing stage that sits directly upstream of the 2-lane SL3 SERDES wrapper, in the tx_clk_in domain. It takes per-lane 64-bit user payload words with a control/data flag and prepends the 2-bit sync header. Every AM_PERIOD emitted words it inserts an alignment marker (AM) on all lanes simultaneously; the RX deskew logic locks on these markers. When the user has no data, it fills with idle control words. Emission is paced by the SERDES TX FIFO partial-empty demand signal.

Parameters:
LANES, 2, number of lanes; must match the SERDES wrapper.
AM_PERIOD, 16384, emitted words per AM cycle, including the AM word; legal range 2..2^AM_CNTR_BITS.
AM_CNTR_BITS, 14, width of the AM spacing counter.

Ports:
clk  input  1  tx_clk_in domain clock.
srst  input  1  synchronous active-high reset; connect to the SERDES tx_srst.
din  input  LANES*64  user payload; lane i is din[i*64+63:i*64], bit 0 is sent first.
din_ctrl  input  LANES  per-lane flag: 1 = control block, 0 = data block.
din_valid  input  1  user word valid for all lanes.
din_ready  output  1  block accepts din this cycle; combinational.
tx_din_pempty  input  1  SERDES TX FIFO demand; high means emit a word this cycle.
tx_din  output  LANES*66  framed words to the SERDES.
tx_valid  output  1  tx_din valid.
am_sent  output  1  one-cycle pulse when an AM word is emitted.
ctrl_collision  output  1  one-cycle pulse when a user control word was replaced by idle.
idle_cnt  output  16  saturating count of idle words emitted.

Behaviour:
- emit = tx_din_pempty & !srst.
- am_due = (am_cntr == 0).
- din_ready = emit & !am_due. A word is accepted when din_valid & din_ready.
- Output registers update on every clk edge; latency from acceptance to tx_din/tx_valid is 1 cycle.
- tx_valid <= emit. When emit = 0, tx_din holds its previous value and no counter advances.
- Word build per lane i, output bits [i*66+65:i*66]:
  - Data word: header bits [1:0] = 2'b10; bits [65:2] = din lane payload.
  - Control word: header bits [1:0] = 2'b01; bits [65:2] = din lane payload.
  - Idle word: header = 2'b01; bits [65:2] = 64'h0.
  - AM word: header = 2'b01; bits [37:34] = 4'b1100; bits [45:38] = lane index i (8 bits); all other payload bits = 0.
- AM word property: frame bit 0 = 1 and bits 37:34 = 1100, so the RX btype is 5'b11001. No other word type produces this btype.
- Priority when emit = 1:
  1. am_due → all lanes emit the AM word and am_sent <= 1; any user word is not accepted.
  2. Otherwise din_valid → all lanes emit data or control words per din_ctrl.
  3. Otherwise all lanes emit idle, and idle_cnt increments, saturating at 16'hFFFF.
- Collision rule: if an accepted lane has din_ctrl = 1 and payload bits [35:32] == 4'b1100, that lane emits the idle word instead and ctrl_collision <= 1 for that cycle. Other lanes are unaffected. The word still counts as accepted.
- am_cntr: increments on each emitted word and wraps from AM_PERIOD-1 to 0. It is frozen while emit = 0.
- Reset (srst = 1), values registered on that clock edge:
  - am_cntr = 0, so the first emitted word after reset is an AM.
  - tx_valid = 0, tx_din = 0, am_sent = 0, ctrl_collision = 0, idle_cnt = 0.
  - din_ready = 0 combinationally.
- Reset mid-operation: any in-flight output word is discarded. There is no partial-AM state, because all lanes are always framed in lockstep.
- srst and tx_din_pempty high together: reset wins.

Test Plan:
- Reset release with tx_din_pempty held at 1 → the first tx_valid cycle carries the AM on both lanes: lane0 bits[37:34] = 1100 and bits[45:38] = 0; lane1 bits[45:38] = 1; am_sent = 1; din_ready = 0 in that cycle.
- AM_PERIOD = 8, tx_din_pempty constant 1, din_valid constant 1 → AMs at emitted words 0, 8, 16; 7 user words accepted between consecutive AMs; no user word is lost or duplicated, as checked by an incrementing payload.
- tx_din_pempty toggled 1,0,0,1 with din_valid = 1 → tx_valid follows with 1-cycle delay; am_cntr is frozen during the 0 cycles; the AM still lands on emitted word 8.
- din_valid = 0 for 5 demand cycles (no AM due) → 5 idle words (header 01, payload 0); idle_cnt = 5.
- Lane1 din_ctrl = 1 with payload bits[35:32] = 1100 → lane1 emits idle, lane0 data passes unchanged, ctrl_collision pulses for one cycle.
- srst asserted for one cycle mid-stream at am_cntr = 5 → next cycle tx_valid = 0 and idle_cnt = 0; the first word after release is an AM.

Source files
------------

// File: rtl/sl3p_tx_am_insert_2ln.sv
// TX framing stage ahead of the 2-lane SL3 SERDES wrapper (tx_clk_in domain).
// Prepends the 2-bit sync header to each lane's 64-bit payload, inserts an
// alignment marker on all lanes every AM_PERIOD emitted words, and fills with
// idle control words when the user has nothing to send. Emission is paced by
// the SERDES TX FIFO demand (tx_din_pempty).
module sl3p_tx_am_insert_2ln #(
    parameter int LANES        = 2,
    parameter int AM_PERIOD    = 16384,
    parameter int AM_CNTR_BITS = 14
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [LANES*64-1:0]   din,
    input  logic [LANES-1:0]      din_ctrl,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  tx_din_pempty,
    output logic [LANES*66-1:0]   tx_din,
    output logic                  tx_valid,
    output logic                  am_sent,
    output logic                  ctrl_collision,
    output logic [15:0]           idle_cnt
);

    localparam logic [AM_CNTR_BITS-1:0] AM_LAST = AM_CNTR_BITS'(AM_PERIOD - 1);
    localparam logic [AM_CNTR_BITS-1:0] CNT_ONE = AM_CNTR_BITS'(1);
    localparam logic [1:0]              HDR_DATA = 2'b10;
    localparam logic [1:0]              HDR_CTRL = 2'b01;
    // Payload nibble that, with a control header, makes the RX btype look like an AM.
    localparam logic [3:0]              AM_NIBBLE = 4'b1100;

    logic [AM_CNTR_BITS-1:0] am_cntr_q, am_cntr_d;
    logic [LANES*66-1:0]     tx_din_q, tx_din_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    am_sent_q, am_sent_d;
    logic                    ctrl_collision_q, ctrl_collision_d;
    logic [15:0]             idle_cnt_q, idle_cnt_d;

    logic emit;
    logic am_due;

    // Reset blocks demand so nothing is accepted or framed during srst.
    assign emit      = tx_din_pempty & ~srst;
    assign am_due    = (am_cntr_q == '0);
    assign din_ready = emit & ~am_due;

    // Next-state framing: AM has priority, then user words, then idle fill.
    always_comb begin
        am_cntr_d        = am_cntr_q;
        tx_din_d         = tx_din_q;
        tx_valid_d       = emit;
        am_sent_d        = 1'b0;
        ctrl_collision_d = 1'b0;
        idle_cnt_d       = idle_cnt_q;

        if (emit) begin
            am_cntr_d = (am_cntr_q == AM_LAST) ? '0 : am_cntr_q + CNT_ONE;

            if (am_due) begin
                am_sent_d = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    tx_din_d[i*66 +: 66]      = '0;
                    tx_din_d[i*66 +: 2]       = HDR_CTRL;
                    tx_din_d[i*66 + 34 +: 4]  = AM_NIBBLE;
                    tx_din_d[i*66 + 38 +: 8]  = 8'(i);
                end
            end else if (din_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    if (!din_ctrl[i]) begin
                        tx_din_d[i*66 +: 66] = {din[i*64 +: 64], HDR_DATA};
                    end else if (din[i*64 + 32 +: 4] == AM_NIBBLE) begin
                        // A control word that would alias an AM at the receiver is
                        // replaced by idle on that lane only.
                        tx_din_d[i*66 +: 66] = {64'h0, HDR_CTRL};
                        ctrl_collision_d     = 1'b1;
                    end else begin
                        tx_din_d[i*66 +: 66] = {din[i*64 +: 64], HDR_CTRL};
                    end
                end
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    tx_din_d[i*66 +: 66] = {64'h0, HDR_CTRL};
                end
                if (idle_cnt_q != 16'hFFFF) begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
        end
    end

    // Output and counter registers; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (srst) begin
            am_cntr_q        <= '0;
            tx_din_q         <= '0;
            tx_valid_q       <= 1'b0;
            am_sent_q        <= 1'b0;
            ctrl_collision_q <= 1'b0;
            idle_cnt_q       <= '0;
        end else begin
            am_cntr_q        <= am_cntr_d;
            tx_din_q         <= tx_din_d;
            tx_valid_q       <= tx_valid_d;
            am_sent_q        <= am_sent_d;
            ctrl_collision_q <= ctrl_collision_d;
            idle_cnt_q       <= idle_cnt_d;
        end
    end

    assign tx_din         = tx_din_q;
    assign tx_valid       = tx_valid_q;
    assign am_sent        = am_sent_q;
    assign ctrl_collision = ctrl_collision_q;
    assign idle_cnt       = idle_cnt_q;

endmodule

// File: tb/tb_sl3p_tx_am_insert_2ln.sv
// Scoreboard bench for sl3p_tx_am_insert_2ln with a short AM period (8).
module tb_sl3p_tx_am_insert_2ln;

    localparam int AMP = 8;
    localparam logic [65:0] AM0  = 66'h0_0000_0030_0000_0001;
    localparam logic [65:0] AM1  = 66'h0_0000_0070_0000_0001;
    localparam logic [65:0] IDLE = 66'h0_0000_0000_0000_0001;

    logic         clk = 1'b0;
    logic         srst;
    logic [127:0] din;
    logic [1:0]   din_ctrl;
    logic         din_valid;
    logic         din_ready;
    logic         tx_din_pempty;
    logic [131:0] tx_din;
    logic         tx_valid;
    logic         am_sent;
    logic         ctrl_collision;
    logic [15:0]  idle_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sl3p_tx_am_insert_2ln #(
        .LANES(2), .AM_PERIOD(AMP), .AM_CNTR_BITS(3)
    ) dut (
        .clk(clk), .srst(srst), .din(din), .din_ctrl(din_ctrl),
        .din_valid(din_valid), .din_ready(din_ready),
        .tx_din_pempty(tx_din_pempty), .tx_din(tx_din), .tx_valid(tx_valid),
        .am_sent(am_sent), .ctrl_collision(ctrl_collision), .idle_cnt(idle_cnt)
    );

    typedef struct packed {
        logic [131:0] word;
        logic         am;
        logic         coll;
    } exp_t;

    exp_t q[$];

    int           m_cnt    = 0;
    logic [15:0]  m_idle   = '0;
    logic [31:0]  seq      = '0;
    logic [131:0] last_exp = '0;
    bit           prev_emit = 1'b0;
    bit           armed     = 1'b0;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Monitor: every valid output word must match the oldest expectation.
    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_tx_valid", 132'(tx_valid), 132'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("tx_din", tx_din, e.word);
                check("am_sent", 132'(am_sent), 132'(e.am));
                check("ctrl_collision", 132'(ctrl_collision), 132'(e.coll));
            end
        end
    end

    // One stimulus cycle: drive at negedge, push the expected framed word.
    task automatic step(input bit rst, input bit pe, input bit v, input logic [1:0] c,
                        input logic [63:0] p0, input logic [63:0] p1);
        exp_t e;
        bit   emit;
        @(negedge clk);
        if (armed) begin
            check("tx_valid_follow", 132'(tx_valid), 132'(prev_emit));
            check("idle_cnt", 132'(idle_cnt), 132'(m_idle));
            if (!prev_emit) check("tx_din_hold", tx_din, last_exp);
        end
        srst = rst; tx_din_pempty = pe; din_valid = v; din_ctrl = c; din = {p1, p0};
        #1;
        emit = pe && !rst;
        check("din_ready", 132'(din_ready), 132'(emit && (m_cnt != 0)));
        if (rst) begin
            m_cnt = 0; m_idle = '0; last_exp = '0;
        end else if (emit) begin
            e.am = 1'b0; e.coll = 1'b0;
            if (m_cnt == 0) begin
                e.word = {AM1, AM0};
                e.am   = 1'b1;
            end else if (v) begin
                e.word[65:0]   = c[0] ? ((p0[35:32] == 4'hC) ? IDLE : {p0, 2'b01}) : {p0, 2'b10};
                e.word[131:66] = c[1] ? ((p1[35:32] == 4'hC) ? IDLE : {p1, 2'b01}) : {p1, 2'b10};
                e.coll = (c[0] && p0[35:32] == 4'hC) || (c[1] && p1[35:32] == 4'hC);
                seq++;
            end else begin
                e.word = {IDLE, IDLE};
                if (m_idle != 16'hFFFF) m_idle++;
            end
            q.push_back(e);
            last_exp = e.word;
            m_cnt = (m_cnt + 1) % AMP;
        end
        prev_emit = emit;
        armed = 1'b1;
    endtask

    task automatic data_step(input bit pe);
        step(1'b0, pe, 1'b1, 2'b00, {32'hA0A0_0000, seq}, {32'hB1B1_0000, seq});
    endtask

    initial begin
        srst = 1'b1; tx_din_pempty = 1'b0; din_valid = 1'b0; din_ctrl = '0; din = '0;

        // Reset with demand asserted: reset wins, nothing accepted.
        step(1'b1, 1'b1, 1'b0, 2'b00, '0, '0);
        step(1'b1, 1'b1, 1'b1, 2'b00, 64'h1, 64'h2);

        // Release: first word AM, then five idle words.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 2'b00, '0, '0);
        @(posedge clk); #1;
        check("idle_cnt_after_5", 132'(idle_cnt), 132'(16'd5));

        // Continuous data with incrementing payload; AMs every 8th word.
        for (int i = 0; i < 20; i++) data_step(1'b1);

        // Demand gaps: 1,0,0,1 repeated; AM position follows emitted words only.
        for (int i = 0; i < 12; i++) data_step((i % 4 == 0) || (i % 4 == 3));

        // Control words: one clean, one that collides on lane 1.
        while (m_cnt == 0 || m_cnt == AMP - 1) data_step(1'b1);
        step(1'b0, 1'b1, 1'b1, 2'b01, 64'h0000_0000_0000_1234, 64'h0000_0000_5678_0000);
        step(1'b0, 1'b1, 1'b1, 2'b10, 64'h1111_2222_3333_4444, 64'h0000_000C_0000_0000);
        data_step(1'b1);

        // Reset mid-stream at am_cntr = 5, then first word after release is AM.
        for (int i = 0; i < AMP && m_cnt != 5; i++) data_step(1'b1);
        check("reached_cnt5", 132'(m_cnt), 132'(5));
        step(1'b1, 1'b1, 1'b1, 2'b00, {32'hA0A0_0000, seq}, {32'hB1B1_0000, seq});
        for (int i = 0; i < 4; i++) data_step(1'b1);
        step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);

        @(negedge clk);
        check("queue_drained", 132'(q.size()), 132'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
